// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage and IF/ID pipeline register for the
//                pipelined RV32I core. Owns the fetch PC, selects the next PC
//                (sequential or execute-stage redirect), applies stall/flush
//                control to the IF/ID register and counts instructions that
//                reach decode as valid.
//
//  Ports
//    clk          : core clock, all state updates on the rising edge
//    rst          : synchronous active-high reset
//    stall_f      : hazard unit hold request for PC and IF/ID
//    pc_src_e     : execute-stage redirect (taken branch / jump)
//    pc_target_e  : execute-stage redirect target
//    imem_addr    : instruction memory address (equals the fetch PC)
//    imem_rdata   : instruction memory read data, valid same cycle
//    instr_d      : registered instruction presented to decode
//    opcode_d     : instr_d[6:0]
//    func3_d      : instr_d[14:12]
//    pc_d         : PC of instr_d
//    pc_plus4_d   : pc_d + 4 (link value for JAL/JALR)
//    valid_d      : instr_d is a real instruction (0 = bubble)
//    misalign_d   : last redirect target had nonzero bits [1:0]
//    fetch_count  : number of valid instructions loaded into IF/ID
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_d,
    output logic [6:0]      opcode_d,
    output logic [2:0]      func3_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            misalign_d,
    output logic [31:0]     fetch_count
);

    localparam logic [XLEN-1:0] c_PC_INC = XLEN'(4);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_pc_f;
    logic [31:0]     r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;
    logic            r_misalign_d;
    logic [31:0]     r_fetch_count;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_pc_plus4_f;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_target_misaligned;
    logic            w_advance;

    // Sequential PC wraps modulo 2^XLEN by construction of the adder width.
    assign w_pc_plus4_f        = r_pc_f + c_PC_INC;

    // Redirect targets are forced word-aligned; the dropped low bits are
    // reported through misalign_d rather than being fetched from.
    assign w_redirect_pc       = {pc_target_e[XLEN-1:2], 2'b00};
    assign w_target_misaligned = |pc_target_e[1:0];

    // A redirect outranks a stall: the stalled instruction is on a wrong
    // path anyway once execute resolves a taken branch or jump.
    assign w_advance           = !pc_src_e && !stall_f;

    // ------------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (pc_src_e) begin
            r_pc_f <= w_redirect_pc;
        end else if (!stall_f) begin
            r_pc_f <= w_pc_plus4_f;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    //   Redirect flushes to a bubble; the instruction fetched during the
    //   redirect cycle belongs to the wrong path and is discarded, so the
    //   first target instruction arrives in decode two edges later.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (pc_src_e) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!stall_f) begin
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4_f;
            r_valid_d    <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Misalignment flag
    //   Raised by the redirect edge only, held across stalls so the hazard
    //   logic cannot make it disappear, cleared by the next advancing edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_d <= 1'b0;
        end else if (pc_src_e) begin
            r_misalign_d <= w_target_misaligned;
        end else if (!stall_f) begin
            r_misalign_d <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Fetched-instruction counter
    //   Counts only edges that load a valid instruction into IF/ID; wraps
    //   naturally at 2^32.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_advance) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all register-driven; no path from imem_rdata to any output)
    // ------------------------------------------------------------------------
    assign imem_addr   = r_pc_f;
    assign instr_d     = r_instr_d;
    assign opcode_d    = r_instr_d[6:0];
    assign func3_d     = r_instr_d[14:12];
    assign pc_d        = r_pc_d;
    assign pc_plus4_d  = r_pc_plus4_d;
    assign valid_d     = r_valid_d;
    assign misalign_d  = r_misalign_d;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
